octseg_reader: RTL and testbench
================================

OCTSEG_READER -- requirements
Module: octseg_reader

Interface
REQ-001 SHALL have parameter NDIG, default 3, meaning the number of digits per scan frame (range 1..8).
REQ-002 SHALL have parameter STABLE_CYC, default 4, meaning the consecutive identical-sample cycles required before a digit is captured (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port seg_n, input, 7 bits: active-low segments, bit0=a through bit6=g.
REQ-006 SHALL have port dig_sel, input, NDIG bits: one-hot digit strobe; bit k high selects digit k.
REQ-007 SHALL have port frame_data, output, 3*NDIG bits: decoded octal digits; digit k occupies bits [3k+2:3k].
REQ-008 SHALL have port frame_err, output, NDIG bits: per-digit illegal-pattern flag.
REQ-009 SHALL have port frame_valid, output, 1 bit: a frame is available.
REQ-010 SHALL have port frame_ready, input, 1 bit: the consumer accepts the frame.
REQ-011 SHALL have port ovf, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-012 SHALL have port seq_err, output, 1 bit: one-cycle pulse when a frame is aborted.

Function
REQ-013 SHALL decode seg_n codes (g..a, hex) to values as follows: 0x40->0, 0x79->1, 0x24->2, 0x30->3, 0x19->4, 0x12->5, 0x02->6, 0x78->7; any other code SHALL be illegal, with value 0 and the err bit set.
REQ-014 SHALL implement the FSM states IDLE, SETTLE, HOLD and DONE.
REQ-015 SHALL move from IDLE to SETTLE for digit 0 when dig_sel equals 1; any other dig_sel value SHALL keep the FSM in IDLE.
REQ-016 SETTLE SHALL count cycles with an unchanged seg_n and an unchanged dig_sel, restarting the count whenever seg_n changes; when the count reaches STABLE_CYC it SHALL latch the digit value and err bit and go to HOLD.
REQ-017 HOLD SHALL wait while the current strobe stays asserted; dig_sel==0 SHALL be an allowed inter-digit gap; the next-digit strobe SHALL enter SETTLE for digit k+1.
REQ-018 Completing capture of digit NDIG-1 SHALL transfer the assembled frame to the output register and go to DONE; DONE SHALL return to IDLE once dig_sel no longer selects digit NDIG-1.
REQ-019 Abort: in SETTLE or HOLD, any strobe that is not one-hot, or any one-hot strobe other than the current or next digit, SHALL pulse seq_err for 1 cycle, discard partial digits, and return to IDLE in the same cycle.
REQ-020 Abort: a strobe dropping in SETTLE before capture SHALL behave the same as REQ-019.
REQ-021 Output handshake: frame_valid SHALL rise the cycle after the transfer; frame_data and frame_err SHALL remain stable while frame_valid=1 and frame_ready=0; the frame SHALL be consumed on frame_valid&&frame_ready.
REQ-022 A transfer that coincides with consumption SHALL load the new frame with frame_valid held at 1 and no ovf.
REQ-023 A transfer while the held frame is unconsumed SHALL keep the old frame and pulse ovf.
REQ-024 Latency: the last digit's first stable cycle SHALL be followed by frame_valid=1 after STABLE_CYC+1 cycles.

Reset
REQ-025 rst_n low SHALL asynchronously force FSM=IDLE, all counters=0, frame_data=0, frame_err=0, frame_valid=0, ovf=0 and seq_err=0.
REQ-026 Reset asserted mid-frame or while a frame is pending SHALL discard all data with no pulse on release.
REQ-027 Reset release SHALL be synchronized internally; the first capture SHALL require a fresh digit-0 strobe.

Configuration
REQ-028 Macro OCTSEG_READER_BLANK_EN defined: code 0x7F (all segments off) SHALL be a legal blank digit with value 0 and err=0, and a frame of all blanks SHALL still be delivered.
REQ-029 Macro OCTSEG_READER_BLANK_EN undefined: code 0x7F SHALL be illegal per REQ-013.

Structure
REQ-030 Package octseg_pkg SHALL hold the eight pattern constants, the blank constant, the FSM state enum and the digit width (3).
REQ-031 Sub-module octseg_decode SHALL be combinational (seg_n -> value[2:0], err) and instantiated once.

Verification
REQ-032 NDIG=3, STABLE_CYC=4, frame_ready=1; strobe digits 0,1,2 with 0x19, 0x02, 0x78 for 8 cycles each -> frame_data=9'o764 (digit2=7, digit1=6, digit0=4), frame_err=0, one frame_valid cycle.
REQ-033 Digit 1 pattern 0x7F, macro undefined -> frame_err=3'b010 and digit1=0; macro defined -> frame_err=0.
REQ-034 frame_ready=0; two complete frames -> first frame held, ovf pulses once; frame_ready raised -> first frame accepted, frame_valid drops.
REQ-035 dig_sel sequence 001 then 100 -> seq_err pulse, no frame; dig_sel=011 during SETTLE -> seq_err pulse.
REQ-036 seg_n toggles every 3 cycles on digit 0 (STABLE_CYC=4) -> no capture; held stable thereafter -> capture after 4 cycles.
REQ-037 rst_n pulsed low mid-frame after digit 1 -> all outputs 0; next full frame decodes correctly.

Source files
------------

// File: rtl/octseg_pkg.sv
// Shared constants and types for the octal seven-segment frame reader.
// Blank-digit support is selected by OCTSEG_READER_BLANK_EN in the decoder.
package octseg_pkg;

    localparam int DIG_W = 3;

    // Active-low segment codes, bit6=g .. bit0=a
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/octseg_decode.sv
// Combinational seven-segment to octal decoder with illegal-pattern flag.
// With OCTSEG_READER_BLANK_EN defined, the all-off code is a legal zero.
module octseg_decode
    import octseg_pkg::*;
(
    input  logic [6:0]       seg_n,
    output logic [DIG_W-1:0] value,
    output logic             err
);

    always_comb begin
        value = '0;
        err   = 1'b0;
        case (seg_n)
            SEG_0: value = 3'd0;
            SEG_1: value = 3'd1;
            SEG_2: value = 3'd2;
            SEG_3: value = 3'd3;
            SEG_4: value = 3'd4;
            SEG_5: value = 3'd5;
            SEG_6: value = 3'd6;
            SEG_7: value = 3'd7;
`ifdef OCTSEG_READER_BLANK_EN
            SEG_BLANK: value = 3'd0;
`endif
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/octseg_reader.sv
// Captures a multiplexed octal seven-segment display scan into whole frames.
// Optional blank-digit decoding: define OCTSEG_READER_BLANK_EN.
module octseg_reader
    import octseg_pkg::*;
#(
    parameter int NDIG       = 3,
    parameter int STABLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_n,
    input  logic [NDIG-1:0]       dig_sel,
    output logic [DIG_W*NDIG-1:0] frame_data,
    output logic [NDIG-1:0]       frame_err,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  ovf,
    output logic                  seq_err
);

    localparam logic [NDIG-1:0] ONE_OH   = NDIG'(1);
    localparam logic [NDIG-1:0] LAST_OH  = ONE_OH << (NDIG - 1);
    localparam logic [7:0]      CNT_LAST = 8'(STABLE_CYC - 1);
    localparam logic [2:0]      IDX_LAST = 3'(NDIG - 1);

    // Reset asserts asynchronously but releases on a clock edge
    logic [1:0] rst_sync;
    logic       core_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign core_rst_n = rst_sync[1];

    state_t                      state, state_nxt;
    logic [2:0]                  idx, idx_nxt;
    logic [7:0]                  cnt, cnt_nxt;
    logic [6:0]                  seg_q, segq_nxt;
    logic [NDIG-1:0][DIG_W-1:0]  dig_q, asm_data;
    logic [NDIG-1:0]             err_q, asm_err;
    logic [NDIG-1:0]             cur_oh, nxt_oh;
    logic [DIG_W-1:0]            dec_val;
    logic                        dec_err, cap, abort, last;

    octseg_decode u_dec (
        .seg_n (seg_n),
        .value (dec_val),
        .err   (dec_err)
    );

    assign cur_oh = ONE_OH << idx;
    assign nxt_oh = cur_oh << 1;
    assign last   = (idx == IDX_LAST);

    // Partial frame with the digit being captured merged in
    always_comb begin
        asm_data = dig_q;
        asm_err  = err_q;
        for (int k = 0; k < NDIG; k++) begin
            if (idx == 3'(k)) begin
                asm_data[k] = dec_val;
                asm_err[k]  = dec_err;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        segq_nxt  = seg_q;
        cap       = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (dig_sel == ONE_OH) begin
                    state_nxt = SETTLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    segq_nxt  = seg_n;
                end
            end
            SETTLE: begin
                // The strobe must stay on the current digit until it is captured
                if (dig_sel != cur_oh) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (seg_n != seg_q) begin
                    segq_nxt = seg_n;
                    cnt_nxt  = '0;
                end else if (cnt == CNT_LAST) begin
                    cap       = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = last ? DONE : HOLD;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            HOLD: begin
                if (dig_sel == cur_oh || dig_sel == '0) begin
                    state_nxt = HOLD;
                end else if (dig_sel == nxt_oh) begin
                    state_nxt = SETTLE;
                    idx_nxt   = idx + 3'd1;
                    cnt_nxt   = '0;
                    segq_nxt  = seg_n;
                end else begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                if (dig_sel != LAST_OH) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            seg_q       <= '0;
            dig_q       <= '0;
            err_q       <= '0;
            frame_data  <= '0;
            frame_err   <= '0;
            frame_valid <= 1'b0;
            ovf         <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            seg_q   <= segq_nxt;
            seq_err <= abort;
            ovf     <= 1'b0;
            if (cap) begin
                dig_q <= asm_data;
                err_q <= asm_err;
            end else if (abort) begin
                dig_q <= '0;
                err_q <= '0;
            end
            // A completed frame only replaces the held one if that one leaves now
            if (cap && last) begin
                if (!frame_valid || frame_ready) begin
                    frame_data  <= asm_data;
                    frame_err   <= asm_err;
                    frame_valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_octseg_reader.sv
// Scoreboard bench for octseg_reader: randomized and directed scans vs. a digit-table model.
module tb_octseg_reader;

    localparam int NDIG = 3;
    localparam int S    = 4;
    localparam logic [6:0] PAT [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    typedef struct {
        logic [8:0] data;
        logic [2:0] err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_n = 7'h7F;
    logic [2:0] dig_sel = 3'b000;
    logic [8:0] frame_data;
    logic [2:0] frame_err;
    logic       frame_valid, frame_ready, ovf, seq_err;

    int   rdy_mode = 1;
    logic rnd_bit = 1'b1;
    assign frame_ready = (rdy_mode == 2) ? rnd_bit : (rdy_mode == 1);

    always #5 clk = ~clk;

    octseg_reader #(.NDIG(NDIG), .STABLE_CYC(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .frame_data  (frame_data),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .ovf         (ovf),
        .seq_err     (seq_err)
    );

    exp_t expq[$];
    int checks = 0, passed = 0;
    int cyc = 0;
    int n_ovf = 0, n_seq = 0, n_vcyc = 0, last_rise = 0, last_start = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Random ready, forced high every 4th cycle so a frame never waits long
    initial forever begin
        @(posedge clk);
        #1;
        rnd_bit = (cyc % 4 == 0) ? 1'b1 : 1'($urandom);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic void ref_dec(input logic [6:0] c, output logic [2:0] v, output logic e);
        v = 3'd0;
        e = 1'b1;
        for (int i = 0; i < 8; i++)
            if (c == PAT[i]) begin
                v = 3'(i);
                e = 1'b0;
            end
`ifdef OCTSEG_READER_BLANK_EN
        if (c == 7'h7F) e = 1'b0;
`endif
    endfunction

    function automatic exp_t model(input logic [2:0][6:0] c);
        exp_t r;
        logic [2:0] v;
        logic e;
        r.data = '0;
        r.err  = '0;
        for (int k = 0; k < NDIG; k++) begin
            ref_dec(c[k], v, e);
            r.data[3*k +: 3] = v;
            r.err[k] = e;
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard on every accepted frame, checks stall stability
    initial begin
        exp_t e;
        logic hold_pend, vprev;
        logic [11:0] held;
        hold_pend = 1'b0;
        vprev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ovf) n_ovf++;
                if (seq_err) n_seq++;
                if (frame_valid) n_vcyc++;
                if (frame_valid && !vprev) last_rise = cyc;
                if (hold_pend && frame_valid)
                    chk("stall_stable", 32'({frame_err, frame_data}), 32'(held));
                if (frame_valid && frame_ready) begin
                    if (expq.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_frame: got data %0o, expected no frame", frame_data);
                    end else begin
                        e = expq.pop_front();
                        chk("frame_data", 32'(frame_data), 32'(e.data));
                        chk("frame_err", 32'(frame_err), 32'(e.err));
                    end
                end
                hold_pend = frame_valid && !frame_ready;
                held = {frame_err, frame_data};
                vprev = frame_valid;
            end else begin
                hold_pend = 1'b0;
                vprev = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1);
    end

    task automatic drive(input logic [2:0] sel, input logic [6:0] seg, input int n);
        dig_sel = sel;
        seg_n = seg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [2:0][6:0] c, input int hold, input int gap,
                              input bit push, input bit glitch);
        logic [2:0] sel;
        if (push) expq.push_back(model(c));
        for (int k = 0; k < NDIG; k++) begin
            sel = 3'b001 << k;
            if (glitch) repeat ($urandom_range(0, 2)) drive(sel, 7'($urandom), 1);
            if (k == NDIG - 1) last_start = cyc;
            drive(sel, c[k], hold);
            if (gap > 0) drive(3'b000, c[k], gap);
        end
        if (gap == 0) drive(3'b000, c[2], 1);
    endtask

    initial begin
        logic [2:0][6:0] c;
        exp_t e;
        int s0, o0, v0;

        // Reset state
        #3;
        chk("rst_frame_data", 32'(frame_data), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_frame_valid", 32'(frame_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_seq_err", 32'(seq_err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(3'b000, 7'h7F, 4);

        // Basic frame and latency
        v0 = n_vcyc;
        e.data = 9'o764;
        e.err = 3'b000;
        expq.push_back(e);
        c = {7'h78, 7'h02, 7'h19};
        send_frame(c, 8, 0, 0, 0);
        drive(3'b000, 7'h7F, 3);
        chk("one_valid_cycle", 32'(n_vcyc - v0), 32'd1);
        chk("latency", 32'(last_rise - last_start), 32'(S + 1));

        // All-off code on digit 1
        e.data = 9'o300;
`ifdef OCTSEG_READER_BLANK_EN
        e.err = 3'b000;
`else
        e.err = 3'b010;
`endif
        expq.push_back(e);
        c = {7'h30, 7'h7F, 7'h40};
        send_frame(c, 6, 1, 0, 0);
        drive(3'b000, 7'h7F, 3);

        // Overflow: second frame dropped while the first waits
        rdy_mode = 0;
        o0 = n_ovf;
        c = {7'h24, 7'h79, 7'h40};
        send_frame(c, 6, 1, 1, 0);
        c = {7'h02, 7'h12, 7'h30};
        send_frame(c, 6, 1, 0, 0);
        drive(3'b000, 7'h7F, 3);
        chk("ovf_pulses", 32'(n_ovf - o0), 32'd1);
        chk("ovf_valid_held", 32'(frame_valid), 32'd1);
        chk("ovf_old_kept", 32'(frame_data), 32'(9'o210));
        rdy_mode = 1;
        drive(3'b000, 7'h7F, 3);
        chk("valid_drops", 32'(frame_valid), 32'd0);

        // Sequence aborts
        s0 = n_seq;
        drive(3'b001, 7'h19, 2);
        drive(3'b100, 7'h19, 2);
        drive(3'b000, 7'h19, 2);
        chk("abort_skip", 32'(n_seq - s0), 32'd1);
        drive(3'b001, 7'h19, 2);
        drive(3'b011, 7'h19, 1);
        drive(3'b000, 7'h19, 2);
        chk("abort_multi", 32'(n_seq - s0), 32'd2);
        drive(3'b001, 7'h19, 2);
        drive(3'b000, 7'h19, 3);
        chk("abort_drop", 32'(n_seq - s0), 32'd3);
        chk("abort_no_frame", 32'(frame_valid), 32'd0);

        // Unstable digit 0 never captured, then stable value captured
        c = {7'h79, 7'h24, 7'h78};
        expq.push_back(model(c));
        for (int r = 0; r < 4; r++) drive(3'b001, (r % 2 == 0) ? 7'h19 : 7'h02, 3);
        drive(3'b001, 7'h78, S + 2);
        drive(3'b010, 7'h24, 6);
        drive(3'b100, 7'h79, 6);
        drive(3'b000, 7'h7F, 3);

        // Transfer coinciding with consumption of the held frame
        rdy_mode = 0;
        o0 = n_ovf;
        c = {7'h12, 7'h19, 7'h30};
        send_frame(c, 6, 1, 1, 0);
        c = {7'h40, 7'h78, 7'h02};
        expq.push_back(model(c));
        drive(3'b001, c[0], 6);
        drive(3'b010, c[1], 6);
        dig_sel = 3'b100;
        seg_n = c[2];
        for (int i = 1; i <= S + 3; i++) begin
            @(posedge clk);
            #1;
            if (i == S) rdy_mode = 1;
        end
        drive(3'b000, 7'h7F, 3);
        chk("coincide_no_ovf", 32'(n_ovf - o0), 32'd0);

        // Reset mid-frame
        s0 = n_seq;
        o0 = n_ovf;
        drive(3'b001, 7'h12, 6);
        drive(3'b010, 7'h24, 6);
        rst_n = 1'b0;
        dig_sel = 3'b000;
        #2;
        chk("midrst_data", 32'(frame_data), 32'd0);
        chk("midrst_err", 32'(frame_err), 32'd0);
        chk("midrst_valid", 32'(frame_valid), 32'd0);
        drive(3'b000, 7'h7F, 2);
        rst_n = 1'b1;
        drive(3'b000, 7'h7F, 4);
        chk("midrst_no_seq", 32'(n_seq - s0), 32'd0);
        chk("midrst_no_ovf", 32'(n_ovf - o0), 32'd0);
        c = {7'h30, 7'h12, 7'h02};
        send_frame(c, 6, 0, 1, 0);
        drive(3'b000, 7'h7F, 3);

        // Randomized frames with glitches, gaps and ready stalls
        rdy_mode = 2;
        s0 = n_seq;
        o0 = n_ovf;
        for (int f = 0; f < 25; f++) begin
            for (int k = 0; k < NDIG; k++)
                c[k] = ($urandom_range(0, 7) == 0) ? 7'($urandom) : PAT[$urandom_range(0, 7)];
            send_frame(c, $urandom_range(S + 1, S + 4), $urandom_range(0, 2), 1, 1);
        end
        drive(3'b000, 7'h7F, 10);
        rdy_mode = 1;
        drive(3'b000, 7'h7F, 4);
        chk("rand_no_seq", 32'(n_seq - s0), 32'd0);
        chk("rand_no_ovf", 32'(n_ovf - o0), 32'd0);
        chk("queue_empty", 32'(expq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
